// File: rtl/kws_argmax_decision.sv
// KWS decision stage: streaming top-1/top-2 tracking over a frame of logits,
// per-frame argmax/margin result and a hold-count detection smoother.
module kws_argmax_decision #(
  parameter int NUM_CLASSES = 20,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int HOLD_FRAMES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              logit_valid,
  input  logic [DATA_W-1:0] logit_data,
  input  logic [ADDR_W-1:0] logit_addr,
  input  logic              frame_abort,
  input  logic [DATA_W-1:0] threshold,
  output logic              busy,
  output logic              result_valid,
  output logic [ADDR_W-1:0] result_class,
  output logic [DATA_W-1:0] result_max,
  output logic [DATA_W-1:0] result_margin,
  output logic              detect,
  output logic              seq_error
);

  localparam int RUN_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CLASSES - 1);
  localparam logic [RUN_W-1:0] HOLD = RUN_W'(HOLD_FRAMES);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DECIDE
  } state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] max1_q, max2_q;
  logic [ADDR_W-1:0] idx_q, cnt_q, last_q;
  logic [RUN_W-1:0] run_q, run_d;

  logic take_first, take_next, seq_err_d, decide;
  logic gt1, gt2, qualify;
  logic [DATA_W:0] diff;
  logic [DATA_W-1:0] margin;

  assign busy = (state_q != IDLE);
  assign gt1 = $signed(logit_data) > max1_q;
  assign gt2 = $signed(logit_data) > max2_q;
  assign decide = (state_q == DECIDE) && !frame_abort;

  // max1 >= max2 always holds, so diff is non-negative; clip above MAX_POS
  always_comb begin
    diff = {max1_q[DATA_W-1], max1_q} - {max2_q[DATA_W-1], max2_q};
    margin = (diff[DATA_W] | diff[DATA_W-1]) ? MAX_POS : diff[DATA_W-1:0];
    qualify = (margin >= threshold);
  end

  always_comb begin
    run_d = '0;
    if (qualify) begin
      if (idx_q == last_q)
        run_d = (run_q == HOLD) ? HOLD : run_q + 1'b1;
      else
        run_d = RUN_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    take_first = 1'b0;
    take_next = 1'b0;
    seq_err_d = 1'b0;
    if (frame_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (logit_valid) begin
            if (logit_addr == '0) begin
              take_first = 1'b1;
              state_d = (NUM_CLASSES == 1) ? DECIDE : COLLECT;
            end else begin
              seq_err_d = 1'b1;
            end
          end
        end
        COLLECT: begin
          if (logit_valid) begin
            if (logit_addr == cnt_q) begin
              take_next = 1'b1;
              if (logit_addr == LAST_ADDR)
                state_d = DECIDE;
            end else begin
              seq_err_d = 1'b1;
              state_d = IDLE;
            end
          end
        end
        DECIDE: begin
          seq_err_d = logit_valid;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max1_q <= '0;
      max2_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      run_q <= '0;
      last_q <= '0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_max <= '0;
      result_margin <= '0;
      detect <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      seq_error <= seq_err_d;
      if (take_first) begin
        max1_q <= $signed(logit_data);
        max2_q <= $signed(MOST_NEG);
        idx_q <= '0;
        cnt_q <= ADDR_W'(1);
      end
      // strict compares keep the lower index on ties
      if (take_next) begin
        if (gt1) begin
          max2_q <= max1_q;
          max1_q <= $signed(logit_data);
          idx_q <= logit_addr;
        end else if (gt2) begin
          max2_q <= $signed(logit_data);
        end
        cnt_q <= cnt_q + 1'b1;
      end
      if (decide) begin
        result_valid <= 1'b1;
        result_class <= idx_q;
        result_max <= max1_q;
        result_margin <= margin;
        run_q <= run_d;
        last_q <= idx_q;
        detect <= (run_d == HOLD);
      end
      if (frame_abort) begin
        run_q <= '0;
        detect <= 1'b0;
      end
    end
  end

endmodule
